// File: rtl/serial_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : serial_tx_fifo
//  Purpose  : Buffered 8N1 UART transmitter. Bytes pushed with a one-cycle
//             write strobe land in a 2^DEPTH_LOG2-entry FIFO and are sent
//             back-to-back on tx_o, RCONST clocks per serial bit.
//  Options  : define SERIAL_TX_PARITY_EN to insert an even-parity bit (8E1).
//  Revision : 1.0  initial release
// ============================================================================
module serial_tx_fifo #(
  parameter int RCONST     = 1302,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [7:0]            wdata_i,
  input  logic                  wr_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DEPTH_LOG2:0]   level_o,
  output logic                  ovf_o,
  output logic                  tx_o,
  output logic                  busy_o
);

  localparam int                  DEPTH      = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] C_DEPTH    = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [10:0]         C_BIT_LAST = 11'(RCONST - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
  logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  ovf_q;

  // Transmit engine
  state_t                state_q;
  logic [10:0]           cnt_q;
  logic [2:0]            idx_q;
  logic [7:0]            data_q;
  logic                  tx_q;
  logic                  busy_q;

  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic                  bit_end;

  // Full is judged on the registered count only, so a pop in the same cycle
  // never makes room for a write that arrives while the FIFO is full.
  assign full    = (count_q == C_DEPTH);
  assign empty   = (count_q == '0);
  assign push    = wr_i && !full;
  assign bit_end = (cnt_q == C_BIT_LAST);
  // Head is consumed when the line is idle, or at the end of a stop bit so the
  // next start bit follows with no idle gap.
  assign pop     = !empty && ((state_q == S_IDLE) || ((state_q == S_STOP) && bit_end));

  // Next-state pointers and occupancy
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) wptr_d = wptr_q + 1'b1;
    if (pop)  rptr_d = rptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO pointer, occupancy and overflow-pulse registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= wr_i && full;
    end
  end

  // FIFO data array; contents are don't-care until written, so no reset
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= wdata_i;
  end

  // Frame sequencer with registered line and busy outputs
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      busy_q <= (state_q != S_IDLE) || !empty;
      case (state_q)
        S_IDLE: begin
          tx_q  <= 1'b1;
          cnt_q <= '0;
          if (pop) begin
            data_q  <= mem_q[rptr_q];
            state_q <= S_START;
            tx_q    <= 1'b0;
          end
        end
        S_START: begin
          if (bit_end) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            state_q <= S_DATA;
            tx_q    <= data_q[0];
          end else begin
            cnt_q <= cnt_q + 11'd1;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (idx_q == 3'd7) begin
`ifdef SERIAL_TX_PARITY_EN
              state_q <= S_PARITY;
              tx_q    <= ^data_q;
`else
              state_q <= S_STOP;
              tx_q    <= 1'b1;
`endif
            end else begin
              idx_q <= idx_q + 3'd1;
              tx_q  <= data_q[idx_q + 3'd1];
            end
          end else begin
            cnt_q <= cnt_q + 11'd1;
          end
        end
`ifdef SERIAL_TX_PARITY_EN
        S_PARITY: begin
          if (bit_end) begin
            cnt_q   <= '0;
            state_q <= S_STOP;
            tx_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 11'd1;
          end
        end
`endif
        S_STOP: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (pop) begin
              data_q  <= mem_q[rptr_q];
              state_q <= S_START;
              tx_q    <= 1'b0;
            end else begin
              state_q <= S_IDLE;
              tx_q    <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 11'd1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  assign full_o  = full;
  assign empty_o = empty;
  assign level_o = count_q;
  assign ovf_o   = ovf_q;
  assign tx_o    = tx_q;
  assign busy_o  = busy_q;

endmodule
`default_nettype wire

// File: doc/serial_tx_fifo.md
# serial_tx_fifo

Buffered 8N1 UART transmitter for the console/debug serial link. Host logic pushes bytes with a single-cycle write strobe into a 16-entry FIFO; the block serialises them back-to-back on `tx` at a rate set by a divider constant. It complements the unbuffered receive path on the same link, letting firmware-side logic burst messages without polling a busy flag per byte.

## Interface
- `RCONST`, 1302: clocks per serial bit (50 MHz / 38400); legal range 2..2047.
- `DEPTH_LOG2`, 4: FIFO depth is 2^DEPTH_LOG2 entries (default 16).
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `wdata`  in  8  byte to enqueue.
- `wr`  in  1  write strobe; one byte enqueued per cycle it is high.
- `full`  out  1  FIFO holds 2^DEPTH_LOG2 entries.
- `empty`  out  1  FIFO holds 0 entries.
- `level`  out  DEPTH_LOG2+1  current FIFO occupancy.
- `ovf`  out  1  one-cycle pulse: a write was dropped because FIFO was full.
- `tx`  out  1  serial line, idle high.
- `busy`  out  1  high while a frame is on the line or FIFO is non-empty.

## Operation
- Reset values: `tx`=1, `busy`=0, `full`=0, `empty`=1, `level`=0, `ovf`=0; FIFO pointers 0, state IDLE, bit counter 0.
- FIFO: circular buffer, read/write pointers DEPTH_LOG2 bits wide, wrap modulo depth; `level` = registered count.
- Write: `wr`=1 and not `full` -> `wdata` stored, `level`+1 at next edge. `wr`=1 and `full` -> byte dropped, `ovf`=1 next cycle, `level` unchanged. Full is judged on registered count; a same-cycle pop does not admit a write when full.
- Simultaneous write and pop (non-full): `level` unchanged, both pointers advance.
- State machine: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE or START.
  - IDLE: `tx`=1. If not `empty`: pop head into shift register, go START.
  - START: `tx`=0 for RCONST clocks.
  - DATA: 8 bits LSB first, each RCONST clocks; 3-bit index 0..7.
  - STOP: `tx`=1 for RCONST clocks; at end, if FIFO non-empty pop and go directly to START (no idle gap), else IDLE.
- Bit timer: 11-bit counter 0..RCONST-1, cleared on every state entry; bit ends when counter == RCONST-1.
- `busy` = (state != IDLE) | !`empty`, registered.
- Reset asserted mid-frame: `tx` forced to 1 immediately, FIFO contents discarded, no partial frame resumes.

## Timing
- `wr` sampled at edge N with FIFO empty and IDLE: `level`=1 after edge N; pop and `tx` falls after edge N+1 (2-clock latency wr-to-start-bit).
- Frame length: 10×RCONST clocks (11×RCONST with parity).
- Back-to-back frames: next start bit begins on the clock after the previous stop bit's last clock; zero idle clocks.
- `busy` falls one clock after the last stop bit completes with FIFO empty.
- `ovf` is a single-cycle pulse per dropped byte, asserted the cycle after the offending `wr`.

## Configuration
- `SERIAL_TX_PARITY_EN` defined: PARITY state inserted between DATA and STOP, transmitting even parity (XOR of the 8 data bits) for RCONST clocks; frame 8E1, 11 bits.
- Undefined: 8N1, DATA goes directly to STOP; no parity logic synthesised.

## Test plan
- RCONST=4, single `wr` of 0xA5 -> `tx` low 2 clocks after strobe, then bits 1,0,1,0,0,1,0,1 each 4 clocks, stop high 4 clocks; `busy` falls after 40 clocks of frame.
- Three consecutive `wr` (0x01,0x02,0x03) -> three contiguous frames, 120 clocks, no idle high between stop and next start; `level` peaks at 2.
- 17 writes in 17 cycles while line busy -> 16 accepted, `full`=1, 17th drops with `ovf` pulse 1 cycle, `level`=16; all 16 bytes later emitted in order.
- Reset pulsed mid-DATA of 0xFF -> `tx`=1 immediately, `level`=0, `empty`=1; next `wr` of 0x55 yields a clean frame.
- Write and pop in same cycle with `level`=3 -> `level` stays 3, pointer wrap across index 15->0 preserves byte order.
- With `SERIAL_TX_PARITY_EN`, send 0x07 -> parity bit 1, frame 44 clocks at RCONST=4; send 0x03 -> parity bit 0.
